// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Lane constants assume a 32-bit datapath split into four byte lanes.
package memory_stage_pkg;
  localparam int BYTE_LANES = 4;
  localparam logic [BYTE_LANES-1:0] BYTE_EN_BYTE = 4'b0001;
  localparam logic [BYTE_LANES-1:0] BYTE_EN_HALF = 4'b0011;

  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} mem_size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} mem_state_e;

  typedef logic mem_write_signal;

  function automatic logic is_misaligned(input logic [1:0] offset, input mem_size_e size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return |offset;
    endcase
  endfunction
endpackage

// File: rtl/memory_stage_aligner.sv
// Combinational lane steering: byte enables, store replication,
// load extraction/extension and misalignment detection.
module load_store_aligner
  import memory_stage_pkg::*;
#(
  parameter int WORD = 32
) (
  input  logic [1:0]            offset,
  input  mem_size_e             size,
  input  logic                  load_signed,
  input  logic [WORD-1:0]       store_data,
  input  logic [WORD-1:0]       rdata,
  output logic [BYTE_LANES-1:0] byte_en,
  output logic [WORD-1:0]       wdata,
  output logic [WORD-1:0]       load_data,
  output logic                  misaligned
);
  logic [WORD-1:0] shifted;

  assign misaligned = is_misaligned(offset, size);

  always_comb begin
    case (size)
      SZ_BYTE: byte_en = BYTE_EN_BYTE << offset;
      SZ_HALF: byte_en = BYTE_EN_HALF << offset;
      default: byte_en = '1;
    endcase
  end

  // Each lane picks the byte it would carry for any legal offset, so the
  // memory only has to honour byte_en.
  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
    assign wdata[8*l +: 8] = (size == SZ_BYTE) ? store_data[7:0] :
                             (size == SZ_HALF) ? store_data[8*(l%2) +: 8] :
                                                 store_data[8*l +: 8];
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{(WORD-8){load_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{(WORD-16){load_signed & shifted[15]}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake FSM,
// WB register and MEM/WB forwarding sources.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ex_valid_i,
  input  mem_op_e               mem_op_i,
  input  mem_size_e             mem_size_i,
  input  logic                  load_signed_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       store_data_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_i,
  input  mem_write_signal       reg_write_en_i,
  output logic                  stall_o,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic                  dmem_we_o,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  output logic [BYTE_LANES-1:0] dmem_byte_en_o,
  input  logic                  dmem_rsp_valid_i,
  input  logic [WORD-1:0]       dmem_rdata_i,
  output logic [ADDR_WIDTH-1:0] reg_dest_MEM_o,
  output logic [WORD-1:0]       reg_data_MEM_o,
  output logic                  mem_write_en_MEM_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_WB_o,
  output logic [WORD-1:0]       reg_data_WB_o,
  output logic                  mem_write_en_WB_o,
  output logic                  align_fault_o
);
  typedef struct packed {
    logic                  valid;
    mem_op_e               op;
    mem_size_e             size;
    logic                  sgn;
    logic [WORD-1:0]       addr;
    logic [WORD-1:0]       sdata;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  we;
  } mem_slot_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] dest;
    logic [WORD-1:0]       data;
    logic                  we;
  } wb_slot_t;

  mem_state_e            state_q, state_d;
  mem_slot_t             mem_q, mem_d;
  wb_slot_t              wb_q, wb_d;
  logic                  complete, start_access, fault, req;
  logic                  mis;
  logic [BYTE_LANES-1:0] lane_be;
  logic [WORD-1:0]       lane_wdata, ld_data;

  assign mem_d = '{valid: ex_valid_i, op: mem_op_i, size: mem_size_i, sgn: load_signed_i,
                   addr: alu_result_i, sdata: store_data_i, dest: reg_dest_i, we: reg_write_en_i};

  load_store_aligner #(.WORD(WORD)) u_aligner (
    .offset      (mem_q.addr[1:0]),
    .size        (mem_q.size),
    .load_signed (mem_q.sgn),
    .store_data  (mem_q.sdata),
    .rdata       (dmem_rdata_i),
    .byte_en     (lane_be),
    .wdata       (lane_wdata),
    .load_data   (ld_data),
    .misaligned  (mis)
  );

  // A misaligned access never leaves IDLE; it just drains like an ALU op.
  assign start_access = ex_valid_i && (mem_op_i != MEM_NONE) &&
                        !is_misaligned(alu_result_i[1:0], mem_size_i);

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE: complete = 1'b1;
      REQ: begin
        if (dmem_req_ready_i) begin
          if (mem_q.op == MEM_STORE) complete = 1'b1;
          else                       state_d  = WAIT;
        end
      end
      WAIT:    complete = dmem_rsp_valid_i;
      default: complete = 1'b1;
    endcase
    if (complete) state_d = start_access ? REQ : IDLE;
  end

  assign fault = (state_q == IDLE) && mem_q.valid && (mem_q.op != MEM_NONE) && mis;

  always_comb begin
    wb_d = '0;
    if (complete && mem_q.valid) begin
      wb_d.dest = mem_q.dest;
      wb_d.data = (mem_q.op == MEM_LOAD) ? ld_data : mem_q.addr;
      wb_d.we   = mem_q.we && (mem_q.op != MEM_STORE) && !fault;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      if (complete) mem_q <= mem_d;
    end
  end

  assign req              = (state_q == REQ);
  assign stall_o          = !complete;
  assign dmem_req_valid_o = req;
  assign dmem_we_o        = req && (mem_q.op == MEM_STORE);
  assign dmem_addr_o      = req ? {mem_q.addr[WORD-1:2], 2'b00} : '0;
  assign dmem_wdata_o     = req ? lane_wdata : '0;
  assign dmem_byte_en_o   = req ? lane_be : '0;
  assign align_fault_o    = fault;

  // Loads are never forwarded from MEM: their data does not exist yet.
  assign reg_dest_MEM_o     = mem_q.valid ? mem_q.dest : '0;
  assign reg_data_MEM_o     = mem_q.valid ? mem_q.addr : '0;
  assign mem_write_en_MEM_o = mem_q.valid && mem_q.we && (mem_q.op != MEM_LOAD);

  assign reg_dest_WB_o     = wb_q.dest;
  assign reg_data_WB_o     = wb_q.data;
  assign mem_write_en_WB_o = wb_q.we;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: reset, lane vector table, directed handshake
// sequences, then random traffic against a byte-array memory model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        ex_valid_i = 1'b0, load_signed_i = 1'b0, reg_write_en_i = 1'b0;
  mem_op_e     mem_op_i = MEM_NONE;
  mem_size_e   mem_size_i = SZ_WORD;
  logic [31:0] alu_result_i = '0, store_data_i = '0, dmem_rdata_i = '0;
  logic [3:0]  reg_dest_i = '0;
  logic        dmem_req_ready_i = 1'b0, dmem_rsp_valid_i = 1'b0;
  logic        stall_o, dmem_req_valid_o, dmem_we_o, mem_write_en_MEM_o, mem_write_en_WB_o, align_fault_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, reg_data_MEM_o, reg_data_WB_o;
  logic [3:0]  dmem_byte_en_o, reg_dest_MEM_o, reg_dest_WB_o;

  memory_stage #(.WORD(32), .ADDR_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ex_valid_i(ex_valid_i), .mem_op_i(mem_op_i),
    .mem_size_i(mem_size_i), .load_signed_i(load_signed_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .reg_dest_i(reg_dest_i), .reg_write_en_i(reg_write_en_i),
    .stall_o(stall_o), .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_byte_en_o(dmem_byte_en_o), .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rdata_i(dmem_rdata_i),
    .reg_dest_MEM_o(reg_dest_MEM_o), .reg_data_MEM_o(reg_data_MEM_o),
    .mem_write_en_MEM_o(mem_write_en_MEM_o), .reg_dest_WB_o(reg_dest_WB_o),
    .reg_data_WB_o(reg_data_WB_o), .mem_write_en_WB_o(mem_write_en_WB_o), .align_fault_o(align_fault_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " stall"}, 32'(stall_o), 0);
    check({tag, " req_valid"}, 32'(dmem_req_valid_o), 0);
    check({tag, " we_mem"}, 32'(mem_write_en_MEM_o), 0);
    check({tag, " we_wb"}, 32'(mem_write_en_WB_o), 0);
    check({tag, " fault"}, 32'(align_fault_o), 0);
    check({tag, " dest_mem"}, 32'(reg_dest_MEM_o), 0);
    check({tag, " data_mem"}, reg_data_MEM_o, 0);
    check({tag, " dest_wb"}, 32'(reg_dest_WB_o), 0);
    check({tag, " data_wb"}, reg_data_WB_o, 0);
  endtask

  task automatic drv(input logic v, input mem_op_e op, input mem_size_e sz, input logic sgn,
                     input logic [31:0] a, input logic [31:0] sd, input logic [3:0] d, input logic we);
    ex_valid_i = v; mem_op_i = op; mem_size_i = sz; load_signed_i = sgn;
    alu_result_i = a; store_data_i = sd; reg_dest_i = d; reg_write_en_i = we;
  endtask

  task automatic bubble();
    drv(1'b0, MEM_NONE, SZ_WORD, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
  endtask

  typedef struct packed {
    mem_op_e     op;
    mem_size_e   size;
    logic        sgn;
    logic [31:0] addr, sdata, rdata;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_fault, exp_wbwe;
    logic [31:0] exp_wbdata;
  } vec_t;

  // One instruction with ready=1 and a response in the first WAIT cycle.
  task automatic run_vec(input int idx, input vec_t v);
    string n;
    int    lat;
    n = $sformatf("vec%0d", idx);
    lat = (v.exp_req && v.op == MEM_LOAD) ? 2 : 1;
    drv(1'b1, v.op, v.size, v.sgn, v.addr, v.sdata, 4'd9, 1'b1);
    dmem_req_ready_i = 1'b1; dmem_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    bubble(); dmem_rsp_valid_i = 1'b1; dmem_rdata_i = v.rdata;
    #1;
    check({n, " fault"}, 32'(align_fault_o), 32'(v.exp_fault));
    check({n, " req_valid"}, 32'(dmem_req_valid_o), 32'(v.exp_req));
    check({n, " stall"}, 32'(stall_o), 32'(lat == 2));
    if (v.exp_req) begin
      check({n, " byte_en"}, 32'(dmem_byte_en_o), 32'(v.exp_be));
      check({n, " addr"}, dmem_addr_o, v.addr & 32'hFFFF_FFFC);
      check({n, " we"}, 32'(dmem_we_o), 32'(v.op == MEM_STORE));
      if (v.op == MEM_STORE) check({n, " wdata"}, dmem_wdata_o, v.exp_wdata);
    end
    if (v.op == MEM_NONE) check({n, " fwd_mem"}, reg_data_MEM_o, v.addr);
    @(negedge clk_i);
    if (lat == 2) @(negedge clk_i);
    dmem_rsp_valid_i = 1'b0;
    #1;
    check({n, " wb_we"}, 32'(mem_write_en_WB_o), 32'(v.exp_wbwe));
    if (v.exp_wbwe) begin
      check({n, " wb_data"}, reg_data_WB_o, v.exp_wbdata);
      check({n, " wb_dest"}, 32'(reg_dest_WB_o), 9);
    end
  endtask

  // Random-phase state: a byte-addressed model and a separate word memory
  // updated only through the DUT's byte enables.
  typedef struct {logic [3:0] dest; logic [31:0] data;} wb_exp_t;
  logic [7:0]  mbytes [64];
  logic [31:0] dev_mem [16];
  wb_exp_t     exp_q[$];
  int          exp_faults = 0, seen_faults = 0;
  bit          rand_done = 0;

  task automatic issue_rand();
    logic [5:0]  a;
    logic [31:0] v;
    mem_op_e     op;
    mem_size_e   sz;
    int          nb;
    op = mem_op_e'($urandom_range(0, 2));
    sz = mem_size_e'($urandom_range(0, 2));
    a  = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == SZ_WORD) a[1:0] = 2'b00;
      else if (sz == SZ_HALF) a[0] = 1'b0;
    end
    drv(($urandom_range(0, 9) != 0), op, sz, 1'($urandom_range(0, 1)), {26'($urandom), a},
        $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    if (!ex_valid_i) return;
    nb = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    if (op != MEM_NONE && (int'(a) % nb) != 0) begin
      exp_faults++;
    end else if (op == MEM_STORE) begin
      for (int i = 0; i < nb; i++) mbytes[int'(a) + i] = store_data_i[8*i +: 8];
    end else if (op == MEM_LOAD) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mbytes[int'(a) + i];
      if (load_signed_i && nb < 4 && v[8*nb-1])
        for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
      if (reg_write_en_i) exp_q.push_back('{reg_dest_i, v});
    end else if (reg_write_en_i) begin
      exp_q.push_back('{reg_dest_i, alu_result_i});
    end
  endtask

  vec_t tv [12];

  initial begin
    tv[0]  = '{MEM_STORE, SZ_BYTE, 1'b0, 32'h43, 32'h1234_5678, 32'h0, 1'b1, 4'b1000, 32'h7878_7878, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{MEM_STORE, SZ_HALF, 1'b0, 32'h42, 32'hAAAA_BEEF, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0};
    tv[2]  = '{MEM_STORE, SZ_WORD, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    tv[3]  = '{MEM_LOAD,  SZ_BYTE, 1'b0, 32'h41, 32'h0, 32'h1234_F0AB, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b1, 32'h0000_00F0};
    tv[4]  = '{MEM_LOAD,  SZ_BYTE, 1'b1, 32'h41, 32'h0, 32'h1234_F0AB, 1'b1, 4'b0010, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0};
    tv[5]  = '{MEM_LOAD,  SZ_BYTE, 1'b1, 32'h43, 32'h0, 32'h7F00_0000, 1'b1, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000_007F};
    tv[6]  = '{MEM_LOAD,  SZ_HALF, 1'b0, 32'h42, 32'h0, 32'h8001_0000, 1'b1, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h0000_8001};
    tv[7]  = '{MEM_LOAD,  SZ_HALF, 1'b1, 32'h40, 32'h0, 32'h0001_7FFF, 1'b1, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0000_7FFF};
    tv[8]  = '{MEM_LOAD,  SZ_WORD, 1'b1, 32'h44, 32'h0, 32'h89AB_CDEF, 1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h89AB_CDEF};
    tv[9]  = '{MEM_LOAD,  SZ_HALF, 1'b0, 32'h43, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
    tv[10] = '{MEM_STORE, SZ_WORD, 1'b0, 32'h42, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0, 32'h0};
    tv[11] = '{MEM_NONE,  SZ_WORD, 1'b0, 32'h55, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0000_0055};

    bubble();
    repeat (3) @(negedge clk_i);
    #1 check_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // ALU op forwards from MEM, then writes back
    @(negedge clk_i);
    dmem_req_ready_i = 1'b1;
    drv(1'b1, MEM_NONE, SZ_WORD, 1'b0, 32'h1234, 32'h0, 4'd3, 1'b1);
    #1 check("alu stall0", 32'(stall_o), 0);
    @(negedge clk_i); bubble();
    #1 check("alu fwd data", reg_data_MEM_o, 32'h1234);
    check("alu fwd we", 32'(mem_write_en_MEM_o), 1);
    check("alu fwd dest", 32'(reg_dest_MEM_o), 3);
    check("alu stall1", 32'(stall_o), 0);
    @(negedge clk_i);
    #1 check("alu wb we", 32'(mem_write_en_WB_o), 1);
    check("alu wb data", reg_data_WB_o, 32'h1234);
    check("alu fwd cleared", 32'(mem_write_en_MEM_o), 0);

    // STRB, ready only on the second REQ cycle
    @(negedge clk_i);
    dmem_req_ready_i = 1'b0;
    drv(1'b1, MEM_STORE, SZ_BYTE, 1'b0, 32'h102, 32'h0000_00AB, 4'd1, 1'b0);
    @(negedge clk_i); bubble();
    #1 check("strb req", 32'(dmem_req_valid_o), 1);
    check("strb stall", 32'(stall_o), 1);
    check("strb be", 32'(dmem_byte_en_o), 32'b0100);
    check("strb wdata", dmem_wdata_o, 32'hABAB_ABAB);
    check("strb addr", dmem_addr_o, 32'h100);
    check("strb we", 32'(dmem_we_o), 1);
    @(negedge clk_i); dmem_req_ready_i = 1'b1;
    #1 check("strb held", 32'(dmem_req_valid_o), 1);
    check("strb held be", 32'(dmem_byte_en_o), 32'b0100);
    check("strb stall end", 32'(stall_o), 0);
    @(negedge clk_i);
    #1 check("strb wb we", 32'(mem_write_en_WB_o), 0);
    check("strb req done", 32'(dmem_req_valid_o), 0);

    // LDRSH, early response ignored, real response 3 cycles after accept
    @(negedge clk_i);
    drv(1'b1, MEM_LOAD, SZ_HALF, 1'b1, 32'h202, 32'h0, 4'd5, 1'b1);
    @(negedge clk_i); bubble();
    dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    #1 check("ldrsh req", 32'(dmem_req_valid_o), 1);
    check("ldrsh be", 32'(dmem_byte_en_o), 32'b1100);
    check("ldrsh addr", dmem_addr_o, 32'h200);
    check("ldrsh no fwd", 32'(mem_write_en_MEM_o), 0);
    check("ldrsh stall req", 32'(stall_o), 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i); dmem_rsp_valid_i = 1'b0; dmem_rdata_i = $urandom;
      #1 check($sformatf("ldrsh stall wait%0d", c), 32'(stall_o), 1);
    end
    @(negedge clk_i); dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
    #1 check("ldrsh stall rsp", 32'(stall_o), 0);
    @(negedge clk_i); dmem_rsp_valid_i = 1'b0;
    #1 check("ldrsh wb we", 32'(mem_write_en_WB_o), 1);
    check("ldrsh wb data", reg_data_WB_o, 32'hFFFF_8001);
    check("ldrsh wb dest", 32'(reg_dest_WB_o), 5);

    // Two back-to-back loads
    @(negedge clk_i);
    drv(1'b1, MEM_LOAD, SZ_WORD, 1'b0, 32'h10, 32'h0, 4'd1, 1'b1);
    @(negedge clk_i);
    drv(1'b1, MEM_LOAD, SZ_WORD, 1'b0, 32'h14, 32'h0, 4'd2, 1'b1);
    #1 check("b2b req1", 32'(dmem_req_valid_o), 1);
    @(negedge clk_i); dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    #1 check("b2b stall rsp1", 32'(stall_o), 0);
    @(negedge clk_i); dmem_rsp_valid_i = 1'b0; bubble();
    #1 check("b2b req2 no gap", 32'(dmem_req_valid_o), 1);
    check("b2b addr2", dmem_addr_o, 32'h14);
    check("b2b wb1", reg_data_WB_o, 32'h1111_1111);
    @(negedge clk_i); dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h2222_2222;
    @(negedge clk_i); dmem_rsp_valid_i = 1'b0;
    #1 check("b2b wb2", reg_data_WB_o, 32'h2222_2222);
    check("b2b wb2 dest", 32'(reg_dest_WB_o), 2);
    check("b2b idle", 32'(dmem_req_valid_o), 0);

    // Misaligned LDR
    @(negedge clk_i);
    drv(1'b1, MEM_LOAD, SZ_WORD, 1'b0, 32'h001, 32'h0, 4'd7, 1'b1);
    @(negedge clk_i); bubble();
    #1 check("mis fault", 32'(align_fault_o), 1);
    check("mis no req", 32'(dmem_req_valid_o), 0);
    check("mis no stall", 32'(stall_o), 0);
    @(negedge clk_i);
    #1 check("mis fault once", 32'(align_fault_o), 0);
    check("mis wb we", 32'(mem_write_en_WB_o), 0);
    check("mis still idle", 32'(dmem_req_valid_o), 0);

    // Reset in WAIT, then a normal load
    @(negedge clk_i);
    drv(1'b1, MEM_LOAD, SZ_WORD, 1'b0, 32'h20, 32'h0, 4'd4, 1'b1);
    @(negedge clk_i); bubble();
    @(negedge clk_i);
    #1 check("rst pre stall", 32'(stall_o), 1);
    check("rst pre dest", 32'(reg_dest_MEM_o), 4);
    #2 rst_n_i = 1'b0;
    #1 check_zero("async rst");
    @(negedge clk_i); rst_n_i = 1'b1;
    drv(1'b1, MEM_LOAD, SZ_WORD, 1'b0, 32'h24, 32'h0, 4'd6, 1'b1);
    @(negedge clk_i); bubble();
    #1 check("post rst req", dmem_addr_o, 32'h24);
    @(negedge clk_i); dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i); dmem_rsp_valid_i = 1'b0;
    #1 check("post rst wb", reg_data_WB_o, 32'hCAFE_F00D);
    check("post rst we", 32'(mem_write_en_WB_o), 1);

    foreach (tv[i]) run_vec(i, tv[i]);

    // Random traffic with random ready/latency and stray responses
    for (int w = 0; w < 16; w++) begin
      dev_mem[w] = $urandom;
      for (int b = 0; b < 4; b++) mbytes[4*w + b] = dev_mem[w][8*b +: 8];
    end
    fork
      begin : drv_proc
        int n = 0, quiet = 0, guard = 0;
        while (!rand_done) begin
          @(negedge clk_i); #2;
          guard++;
          if (!stall_o) begin
            if (n < 300) begin issue_rand(); n++; end
            else begin bubble(); quiet++; end
          end else quiet = 0;
          if (quiet >= 3) rand_done = 1;
          if (guard > 20000) begin
            total++; bad++;
            $display("FAIL rand timeout: issued %0d of 300", n);
            rand_done = 1;
          end
        end
      end
      begin : dev_proc
        bit pend = 0; int lat = 0; logic [31:0] pdata = '0;
        while (!rand_done) begin
          @(negedge clk_i); #1;
          dmem_rsp_valid_i = 1'b0; dmem_rdata_i = $urandom;
          if (pend) begin
            if (lat == 0) begin dmem_rsp_valid_i = 1'b1; dmem_rdata_i = pdata; pend = 0; end
            else lat--;
          end else if ($urandom_range(0, 9) == 0) dmem_rsp_valid_i = 1'b1;
          dmem_req_ready_i = ($urandom_range(0, 9) < 6);
          if (dmem_req_valid_o && dmem_req_ready_i) begin
            check("rand addr align", 32'(dmem_addr_o[1:0]), 0);
            if (dmem_we_o) begin
              for (int l = 0; l < 4; l++)
                if (dmem_byte_en_o[l]) dev_mem[dmem_addr_o[5:2]][8*l +: 8] = dmem_wdata_o[8*l +: 8];
            end else begin
              pend = 1; lat = $urandom_range(0, 2); pdata = dev_mem[dmem_addr_o[5:2]];
            end
          end
        end
      end
      begin : chk_proc
        wb_exp_t e;
        while (!rand_done) begin
          @(negedge clk_i); #3;
          if (align_fault_o) seen_faults++;
          if (mem_write_en_WB_o) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL rand wb extra: got write r%0d=%h want none", reg_dest_WB_o, reg_data_WB_o);
            end else begin
              e = exp_q.pop_front();
              check("rand wb dest", 32'(reg_dest_WB_o), 32'(e.dest));
              check("rand wb data", reg_data_WB_o, e.data);
            end
          end
        end
      end
    join
    check("rand faults", seen_faults, exp_faults);
    check("rand leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
